// File: rtl/tcam_pkg.sv
// Shared widths and types for the TCAM request path: command encoding,
// controller states and the captured request bundle.
package tcam_pkg;
    localparam int TCAM_ADDR_W = 28;
    localparam int TCAM_DATA_W = 32;
    localparam int TCAM_MASK_W = 4;
    localparam int TCAM_PMA_W  = 6;

    typedef enum logic {
        CMD_SEARCH = 1'b0,
        CMD_WRITE  = 1'b1
    } tcam_cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } tcam_ctrl_state_e;

    typedef struct packed {
        tcam_cmd_e              cmd;
        logic [TCAM_ADDR_W-1:0] addr;
        logic [TCAM_DATA_W-1:0] wdata;
        logic [TCAM_MASK_W-1:0] wmask;
    } tcam_req_t;
endpackage

// File: rtl/tcam_req_ctrl.sv
// Sequences one search/write command at a time into the TCAM macro, waits out
// its read latency and hands the priority-encoded match back as a response.
module tcam_req_ctrl
    import tcam_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 32
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_req_valid,
    output logic                   out_req_ready,
    input  logic                   in_req_cmd,
    input  logic [TCAM_ADDR_W-1:0] in_req_addr,
    input  logic [TCAM_DATA_W-1:0] in_req_wdata,
    input  logic [TCAM_MASK_W-1:0] in_req_wmask,
    output logic                   out_resp_valid,
    input  logic                   in_resp_ready,
    output logic [TCAM_PMA_W-1:0]  out_resp_pma,
    output logic                   out_resp_is_write,
    output logic                   out_tcam_csb,
    output logic                   out_tcam_web,
    output logic [TCAM_MASK_W-1:0] out_tcam_wmask,
    output logic [TCAM_ADDR_W-1:0] out_tcam_addr,
    output logic [TCAM_DATA_W-1:0] out_tcam_wdata,
    input  logic [TCAM_PMA_W-1:0]  in_tcam_pma,
    output logic                   out_busy,
    output logic [CNT_W-1:0]       out_search_cnt,
    output logic [CNT_W-1:0]       out_write_cnt
);

    // WAIT lasts LATENCY cycles: the counter counts down to zero inclusive.
    localparam logic [2:0]       LAT_LOAD = 3'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tcam_ctrl_state_e      state_q, state_d;
    tcam_req_t             req_q, req_d;
    logic [2:0]            lat_q, lat_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [TCAM_PMA_W-1:0] resp_pma_q, resp_pma_d;
    logic                  resp_is_write_q, resp_is_write_d;
    logic [CNT_W-1:0]      search_cnt_q, search_cnt_d;
    logic [CNT_W-1:0]      write_cnt_q, write_cnt_d;

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        lat_d           = lat_q;
        csb_d           = 1'b1;
        web_d           = 1'b1;
        resp_pma_d      = resp_pma_q;
        resp_is_write_d = resp_is_write_q;
        search_cnt_d    = search_cnt_q;
        write_cnt_d     = write_cnt_q;

        case (state_q)
            IDLE: begin
                // csb/web are loaded on the accept edge so the pins are low exactly during ISSUE.
                if (in_req_valid) begin
                    req_d.cmd   = in_req_cmd ? CMD_WRITE : CMD_SEARCH;
                    req_d.addr  = in_req_addr;
                    req_d.wdata = in_req_wdata;
                    req_d.wmask = in_req_wmask;
                    csb_d       = 1'b0;
                    web_d       = ~in_req_cmd;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                resp_is_write_d = (req_q.cmd == CMD_WRITE);
                if (req_q.cmd == CMD_WRITE) begin
                    resp_pma_d = '0;
                    state_d    = RESP;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == 3'd0) begin
                    resp_pma_d = in_tcam_pma;
                    state_d    = RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: begin
                if (in_resp_ready) begin
                    if (resp_is_write_q) begin
                        write_cnt_d = write_cnt_q + CNT_ONE;
                    end else begin
                        search_cnt_d = search_cnt_q + CNT_ONE;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q         <= IDLE;
            req_q           <= '0;
            lat_q           <= '0;
            csb_q           <= 1'b1;
            web_q           <= 1'b1;
            resp_pma_q      <= '0;
            resp_is_write_q <= 1'b0;
            search_cnt_q    <= '0;
            write_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            lat_q           <= lat_d;
            csb_q           <= csb_d;
            web_q           <= web_d;
            resp_pma_q      <= resp_pma_d;
            resp_is_write_q <= resp_is_write_d;
            search_cnt_q    <= search_cnt_d;
            write_cnt_q     <= write_cnt_d;
        end
    end

    assign out_req_ready     = (state_q == IDLE);
    assign out_busy          = (state_q != IDLE);
    assign out_resp_valid    = (state_q == RESP);
    assign out_resp_pma      = resp_pma_q;
    assign out_resp_is_write = resp_is_write_q;
    assign out_tcam_csb      = csb_q;
    assign out_tcam_web      = web_q;
    assign out_tcam_addr     = req_q.addr;
    assign out_tcam_wdata    = req_q.wdata;
    assign out_tcam_wmask    = req_q.wmask;
    assign out_search_cnt    = search_cnt_q;
    assign out_write_cnt     = write_cnt_q;

endmodule

// File: tb/tb_tcam_req_ctrl.sv
// Bench for tcam_req_ctrl built with LATENCY=3 and 4-bit counters: directed
// scenarios with literal expectations plus randomized traffic against a
// transaction-timing model.
`timescale 1ns/1ps
module tb_tcam_req_ctrl;
    localparam int L  = 3;
    localparam int CW = 4;

    logic              in_clk = 1'b0;
    logic              in_rst = 1'b1;
    logic              in_req_valid = 1'b0;
    logic              out_req_ready;
    logic              in_req_cmd = 1'b0;
    logic [27:0]       in_req_addr = '0;
    logic [31:0]       in_req_wdata = '0;
    logic [3:0]        in_req_wmask = '0;
    logic              out_resp_valid;
    logic              in_resp_ready = 1'b1;
    logic [5:0]        out_resp_pma;
    logic              out_resp_is_write;
    logic              out_tcam_csb;
    logic              out_tcam_web;
    logic [3:0]        out_tcam_wmask;
    logic [27:0]       out_tcam_addr;
    logic [31:0]       out_tcam_wdata;
    logic [5:0]        in_tcam_pma = '0;
    logic              out_busy;
    logic [CW-1:0]     out_search_cnt;
    logic [CW-1:0]     out_write_cnt;

    int checks = 0;
    int errors = 0;

    // Model: one command in flight, timed from the cycle index of its accept edge.
    int          cyc = 0;
    int          acc = 0;
    bit          act = 1'b0;
    bit          m_cmd = 1'b0;
    logic [27:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wmask = '0;
    logic [5:0]  m_pma = '0;
    int          scnt = 0;
    int          wcnt = 0;

    tcam_req_ctrl #(.LATENCY(L), .CNT_W(CW)) dut (
        .in_clk(in_clk),
        .in_rst(in_rst),
        .in_req_valid(in_req_valid),
        .out_req_ready(out_req_ready),
        .in_req_cmd(in_req_cmd),
        .in_req_addr(in_req_addr),
        .in_req_wdata(in_req_wdata),
        .in_req_wmask(in_req_wmask),
        .out_resp_valid(out_resp_valid),
        .in_resp_ready(in_resp_ready),
        .out_resp_pma(out_resp_pma),
        .out_resp_is_write(out_resp_is_write),
        .out_tcam_csb(out_tcam_csb),
        .out_tcam_web(out_tcam_web),
        .out_tcam_wmask(out_tcam_wmask),
        .out_tcam_addr(out_tcam_addr),
        .out_tcam_wdata(out_tcam_wdata),
        .in_tcam_pma(in_tcam_pma),
        .out_busy(out_busy),
        .out_search_cnt(out_search_cnt),
        .out_write_cnt(out_write_cnt)
    );

    initial forever #5 in_clk = ~in_clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Issue cycle is the cycle right after the accept edge; the response follows
    // one cycle later for a write, LATENCY+1 cycles later for a search.
    function automatic bit m_valid();
        return act && (cyc >= acc + (m_cmd ? 1 : L + 1));
    endfunction

    always @(posedge in_clk) begin
        cyc <= cyc + 1;
        if (in_rst) begin
            act     <= 1'b0;
            m_cmd   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wmask <= '0;
            m_pma   <= '0;
            scnt    <= 0;
            wcnt    <= 0;
        end else begin
            if (act && !m_cmd && cyc == acc + L)
                m_pma <= in_tcam_pma;
            if (m_valid() && in_resp_ready) begin
                act <= 1'b0;
                if (m_cmd) wcnt <= (wcnt + 1) % (1 << CW);
                else       scnt <= (scnt + 1) % (1 << CW);
            end else if (!act && in_req_valid) begin
                act     <= 1'b1;
                acc     <= cyc + 1;
                m_cmd   <= in_req_cmd;
                m_addr  <= in_req_addr;
                m_wdata <= in_req_wdata;
                m_wmask <= in_req_wmask;
            end
        end
    end

    always @(negedge in_clk) begin
        if (in_rst) begin
            chk("rst_csb",        32'(out_tcam_csb),      32'd1);
            chk("rst_web",        32'(out_tcam_web),      32'd1);
            chk("rst_addr",       32'(out_tcam_addr),     32'd0);
            chk("rst_wdata",      out_tcam_wdata,         32'd0);
            chk("rst_wmask",      32'(out_tcam_wmask),    32'd0);
            chk("rst_resp_valid", 32'(out_resp_valid),    32'd0);
            chk("rst_resp_pma",   32'(out_resp_pma),      32'd0);
            chk("rst_is_write",   32'(out_resp_is_write), 32'd0);
            chk("rst_busy",       32'(out_busy),          32'd0);
            chk("rst_req_ready",  32'(out_req_ready),     32'd1);
            chk("rst_search_cnt", 32'(out_search_cnt),    32'd0);
            chk("rst_write_cnt",  32'(out_write_cnt),     32'd0);
        end else begin
            chk("req_ready",  32'(out_req_ready),  32'(!act));
            chk("busy",       32'(out_busy),       32'(act));
            chk("csb",        32'(out_tcam_csb),   32'(!(act && cyc == acc)));
            chk("web",        32'(out_tcam_web),   32'(!(act && cyc == acc && m_cmd)));
            chk("tcam_addr",  32'(out_tcam_addr),  32'(m_addr));
            chk("tcam_wdata", out_tcam_wdata,      m_wdata);
            chk("tcam_wmask", 32'(out_tcam_wmask), 32'(m_wmask));
            chk("resp_valid", 32'(out_resp_valid), 32'(m_valid()));
            if (m_valid()) begin
                chk("resp_pma",      32'(out_resp_pma),      32'(m_cmd ? 6'd0 : m_pma));
                chk("resp_is_write", 32'(out_resp_is_write), 32'(m_cmd));
            end
            chk("search_cnt", 32'(out_search_cnt), 32'(scnt));
            chk("write_cnt",  32'(out_write_cnt),  32'(wcnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    // Returns in the issue cycle, one step after the accept edge.
    task automatic send(input logic cmd, input logic [27:0] addr,
                        input logic [31:0] wd, input logic [3:0] wm);
        int n;
        n = 0;
        in_req_valid = 1'b1;
        in_req_cmd   = cmd;
        in_req_addr  = addr;
        in_req_wdata = wd;
        in_req_wmask = wm;
        while (out_req_ready !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(out_req_ready), 32'd1);
        tick(1);
        in_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (out_busy !== 1'b0 && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(out_busy), 32'd0);
    endtask

    initial begin
        tick(2);
        chk("init_csb",       32'(out_tcam_csb),   32'd1);
        chk("init_req_ready", 32'(out_req_ready),  32'd1);
        chk("init_cnt",       32'(out_search_cnt), 32'd0);
        in_rst = 1'b0;
        tick(1);

        // Write then search.
        in_tcam_pma = 6'h33;
        send(1'b1, 28'h000_0005, 32'h0000_00FF, 4'hF);
        chk("w_csb",   32'(out_tcam_csb),   32'd0);
        chk("w_web",   32'(out_tcam_web),   32'd0);
        chk("w_addr",  32'(out_tcam_addr),  32'h5);
        chk("w_wdata", out_tcam_wdata,      32'hFF);
        chk("w_wmask", 32'(out_tcam_wmask), 32'hF);
        tick(1);
        chk("w_csb_after",  32'(out_tcam_csb),      32'd1);
        chk("w_resp_valid", 32'(out_resp_valid),    32'd1);
        chk("w_is_write",   32'(out_resp_is_write), 32'd1);
        chk("w_pma",        32'(out_resp_pma),      32'd0);
        tick(1);
        chk("w_cnt",        32'(out_write_cnt),     32'd1);
        chk("w_resp_done",  32'(out_resp_valid),    32'd0);

        in_tcam_pma = 6'h11;
        send(1'b0, 28'h000_0005, 32'h0, 4'h0);
        chk("s_csb",  32'(out_tcam_csb),  32'd0);
        chk("s_web",  32'(out_tcam_web),  32'd1);
        chk("s_addr", 32'(out_tcam_addr), 32'h5);
        tick(L);
        chk("s_not_yet", 32'(out_resp_valid), 32'd0);
        in_tcam_pma = 6'h2A;
        tick(1);
        chk("s_resp_valid", 32'(out_resp_valid), 32'd1);
        chk("s_pma",        32'(out_resp_pma),   32'h2A);
        in_tcam_pma = 6'h3F;
        tick(1);
        chk("s_cnt", 32'(out_search_cnt), 32'd1);

        // Back-pressure on a search response.
        in_resp_ready = 1'b0;
        in_tcam_pma   = 6'h15;
        send(1'b0, 28'h000_00AB, 32'h0, 4'h0);
        tick(L + 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",     32'(out_resp_valid), 32'd1);
            chk("bp_req_ready", 32'(out_req_ready),  32'd0);
            chk("bp_pma",       32'(out_resp_pma),   32'h15);
            in_req_valid = (i == 4);
            in_req_cmd   = 1'b1;
            in_req_addr  = 28'h123;
            in_tcam_pma  = 6'($urandom);
            tick(1);
        end
        in_req_valid = 1'b0;
        chk("bp_cnt_held", 32'(out_search_cnt), 32'd1);
        in_resp_ready = 1'b1;
        tick(1);
        chk("bp_cnt", 32'(out_search_cnt), 32'd2);
        tick(1);
        chk("bp_no_issue", 32'(out_tcam_csb), 32'd1);

        // Request presented in the response-handshake cycle; wmask=0 write with high address bits.
        in_resp_ready = 1'b0;
        send(1'b1, 28'hFFF_C123, 32'hDEAD_BEEF, 4'h0);
        chk("h_addr",  32'(out_tcam_addr),  32'hFFF_C123);
        chk("h_wmask", 32'(out_tcam_wmask), 32'h0);
        chk("h_web",   32'(out_tcam_web),   32'd0);
        tick(1);
        in_req_valid  = 1'b1;
        in_req_cmd    = 1'b0;
        in_req_addr   = 28'h7;
        in_resp_ready = 1'b1;
        chk("h_ready_low", 32'(out_req_ready), 32'd0);
        tick(1);
        chk("h_ready_after", 32'(out_req_ready), 32'd1);
        chk("h_csb_idle",    32'(out_tcam_csb),  32'd1);
        chk("h_wcnt",        32'(out_write_cnt), 32'd2);
        tick(1);
        in_req_valid = 1'b0;
        chk("h_csb_issue", 32'(out_tcam_csb),  32'd0);
        chk("h_addr2",     32'(out_tcam_addr), 32'h7);
        tick(1);
        chk("h_csb_once", 32'(out_tcam_csb), 32'd1);
        wait_idle();
        chk("h_scnt", 32'(out_search_cnt), 32'd3);

        // Asynchronous reset while the TCAM is selected.
        send(1'b0, 28'h1, 32'h0, 4'h0);
        #2;
        in_rst = 1'b1;
        #1;
        chk("ar_csb",   32'(out_tcam_csb),   32'd1);
        chk("ar_busy",  32'(out_busy),       32'd0);
        chk("ar_ready", 32'(out_req_ready),  32'd1);
        chk("ar_scnt",  32'(out_search_cnt), 32'd0);
        chk("ar_wcnt",  32'(out_write_cnt),  32'd0);
        @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        tick(1);

        // Asynchronous reset with a response pending.
        in_resp_ready = 1'b0;
        send(1'b1, 28'h9, 32'h1, 4'h1);
        tick(1);
        chk("ar2_valid_before", 32'(out_resp_valid), 32'd1);
        #2;
        in_rst = 1'b1;
        #1;
        chk("ar2_valid", 32'(out_resp_valid),    32'd0);
        chk("ar2_isw",   32'(out_resp_is_write), 32'd0);
        @(posedge in_clk);
        #1;
        in_rst        = 1'b0;
        in_resp_ready = 1'b1;
        tick(1);
        chk("ar2_ready", 32'(out_req_ready), 32'd1);
        chk("ar2_wcnt",  32'(out_write_cnt), 32'd0);

        // 17 searches wrap a 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            in_tcam_pma = 6'($urandom);
            send(1'b0, 28'($urandom), 32'h0, 4'h0);
            wait_idle();
        end
        chk("wrap_scnt", 32'(out_search_cnt), 32'd1);
        chk("wrap_wcnt", 32'(out_write_cnt),  32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            in_req_valid  = ($urandom_range(0, 2) == 0);
            in_req_cmd    = 1'($urandom_range(0, 1));
            in_req_addr   = 28'($urandom);
            in_req_wdata  = $urandom;
            in_req_wmask  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            in_resp_ready = ($urandom_range(0, 3) != 0);
            in_tcam_pma   = 6'($urandom);
            tick(1);
        end
        in_req_valid  = 1'b0;
        in_resp_ready = 1'b1;
        wait_idle();
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
